// File: rtl/br_cdc_fifo_pkg.sv
// Shared types and helpers for the CDC FIFO push arbiter and its pop-side demux.
// Tag layout on the FIFO word is {id, last}, placed above the payload.
package br_cdc_fifo_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StHold   = 2'd1,
        StLocked = 2'd2
    } arb_state_e;

    localparam int unsigned TagMaxWidth = 32;

    function automatic int unsigned calc_id_width(input int unsigned num);
        return (num <= 2) ? 1 : $clog2(num);
    endfunction

    function automatic logic [TagMaxWidth-1:0] pack_tag(input logic [TagMaxWidth-2:0] id,
                                                        input logic last);
        return {id, last};
    endfunction

    function automatic logic tag_last(input logic [TagMaxWidth-1:0] tag);
        return tag[0];
    endfunction

    function automatic logic [TagMaxWidth-2:0] tag_id(input logic [TagMaxWidth-1:0] tag);
        return tag[TagMaxWidth-1:1];
    endfunction

endpackage

// File: rtl/br_arb_rr_ptr_select.sv
// Combinational round-robin search: first set bit of req_i at or above ptr_i, with wrap.
module br_arb_rr_ptr_select #(
    parameter int unsigned NumRequesters = 2,
    parameter int unsigned IdWidth       = 1
) (
    input  logic [NumRequesters-1:0] req_i,
    input  logic [IdWidth-1:0]       ptr_i,
    output logic                     valid_o,
    output logic [IdWidth-1:0]       idx_o
);

    int unsigned j;

    // Walk offsets from farthest to nearest so the nearest hit from ptr_i wins.
    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        j       = 0;
        for (int k = NumRequesters - 1; k >= 0; k--) begin
            j = (32'(ptr_i) + unsigned'(k)) % NumRequesters;
            if (req_i[j]) begin
                valid_o = 1'b1;
                idx_o   = IdWidth'(j);
            end
        end
    end

endmodule

// File: rtl/br_cdc_fifo_push_arb.sv
// Packet-granular round-robin scheduler sharing one CDC FIFO push port among requesters.
// Offers are held stable once presented; each pushed word carries {id, last, data}.
module br_cdc_fifo_push_arb
    import br_cdc_fifo_pkg::*;
#(
    parameter int unsigned NumRequesters = 2,
    parameter int unsigned Width         = 8,
    parameter int unsigned MinGrantSlots = 1,
    parameter int unsigned Depth         = 2,
    localparam int unsigned IdWidth      = calc_id_width(NumRequesters),
    localparam int unsigned PushWidth    = IdWidth + 1 + Width,
    localparam int unsigned CountWidth   = $clog2(Depth + 1)
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic [NumRequesters-1:0]         req_valid_i,
    output logic [NumRequesters-1:0]         req_ready_o,
    input  logic [NumRequesters-1:0]         req_last_i,
    input  logic [NumRequesters*Width-1:0]   req_data_i,
    output logic                             push_valid_o,
    input  logic                             push_ready_i,
    output logic [PushWidth-1:0]             push_data_o,
    input  logic [CountWidth-1:0]            push_slots_i,
    output logic [IdWidth-1:0]               grant_id_o,
    output logic                             locked_o
);

    localparam logic [CountWidth-1:0] MinSlots = CountWidth'(MinGrantSlots);

    arb_state_e           state_q, state_d;
    logic [IdWidth-1:0]   owner_q, owner_d;
    logic [IdWidth-1:0]   rr_ptr_q, rr_ptr_d;

    logic                 cand_valid;
    logic [IdWidth-1:0]   cand_idx;
    logic [IdWidth-1:0]   sel_idx;
    logic                 offer;
    logic                 accept;
    logic                 sel_last;
    logic [Width-1:0]     sel_data;
    logic [TagMaxWidth-2:0] id_ext;
    logic [TagMaxWidth-1:0] tag_full;
    logic                 unused_tag;

    function automatic logic [IdWidth-1:0] ptr_inc(input logic [IdWidth-1:0] p);
        return (32'(p) == NumRequesters - 1) ? '0 : p + IdWidth'(1);
    endfunction

    br_arb_rr_ptr_select #(
        .NumRequesters(NumRequesters),
        .IdWidth      (IdWidth)
    ) u_rr_select (
        .req_i  (req_valid_i),
        .ptr_i  (rr_ptr_q),
        .valid_o(cand_valid),
        .idx_o  (cand_idx)
    );

    // Slot check only gates a fresh grant; held and in-packet words bypass it.
    always_comb begin
        sel_idx = owner_q;
        offer   = 1'b0;
        case (state_q)
            StIdle: begin
                sel_idx = cand_idx;
                offer   = cand_valid && (push_slots_i >= MinSlots);
            end
            StHold, StLocked: offer = req_valid_i[owner_q];
            default: offer = 1'b0;
        endcase
        if (!rst_ni) begin
            offer = 1'b0;
        end
    end

    always_comb begin
        accept       = offer & push_ready_i;
        sel_last     = req_last_i[sel_idx];
        sel_data     = req_data_i[Width*int'(sel_idx) +: Width];
        id_ext       = (TagMaxWidth-1)'(sel_idx);
        tag_full     = pack_tag(id_ext, sel_last);
        unused_tag   = ^tag_full[TagMaxWidth-1:IdWidth+1];
        push_valid_o = offer;
        push_data_o  = {tag_full[IdWidth:0], sel_data};
        req_ready_o  = '0;
        if (accept) begin
            req_ready_o[sel_idx] = 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            StIdle, StHold: begin
                if (offer) begin
                    owner_d = sel_idx;
                    if (!accept) begin
                        state_d = StHold;
                    end else if (sel_last) begin
                        state_d  = StIdle;
                        rr_ptr_d = ptr_inc(sel_idx);
                    end else begin
                        state_d = StLocked;
                    end
                end
            end
            StLocked: begin
                if (accept && sel_last) begin
                    state_d  = StIdle;
                    rr_ptr_d = ptr_inc(owner_q);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            owner_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign locked_o   = rst_ni && (state_q != StIdle);
    assign grant_id_o = locked_o ? owner_q : '0;

`ifndef SYNTHESIS
    a_ready_onehot0: assert property (@(posedge clk_i) disable iff (!rst_ni)
        $onehot0(req_ready_o));
    a_push_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (push_valid_o && !push_ready_i) |=> (push_valid_o && $stable(push_data_o)));
    a_ptr_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (32'(rr_ptr_q) < NumRequesters) && (32'(owner_q) < NumRequesters));
`endif

endmodule
